// File: rtl/prng_pkg.sv
// Shared FSM state type and LFSR helpers for the pseudo-random word generator.
// Tap masks are returned at the widest supported length; callers keep the low STATE_WIDTH bits.
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } prng_state_e;

    localparam int unsigned LFSR_MAX_W = 128;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
        logic [LFSR_MAX_W-1:0] mask;
        mask = '0;
        case (width)
            32: begin
                mask[31] = 1'b1;
                mask[29] = 1'b1;
                mask[25] = 1'b1;
                mask[24] = 1'b1;
            end
            64: begin
                mask[63] = 1'b1;
                mask[62] = 1'b1;
                mask[60] = 1'b1;
                mask[59] = 1'b1;
            end
            128: begin
                mask[127] = 1'b1;
                mask[125] = 1'b1;
                mask[100] = 1'b1;
                mask[98]  = 1'b1;
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

    // Bits above the real LFSR length may carry junk; the mask never selects them.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] state,
                                                         input logic [LFSR_MAX_W-1:0] mask);
        return {state[LFSR_MAX_W-2:0], ^(state & mask)};
    endfunction

endpackage

// File: rtl/lfsr_unroll.sv
// Combinational BITS_PER_CYCLE-step unroll of the Fibonacci LFSR.
// fb_bits holds the feedback bits with the earliest step in the MSB.
module lfsr_unroll
    import prng_pkg::*;
#(
    parameter int unsigned STATE_WIDTH    = 64,
    parameter int unsigned BITS_PER_CYCLE = 8
) (
    input  logic [STATE_WIDTH-1:0]    state,
    output logic [STATE_WIDTH-1:0]    next_state,
    output logic [BITS_PER_CYCLE-1:0] fb_bits
);

    localparam logic [LFSR_MAX_W-1:0] TAP_MASK = lfsr_taps(STATE_WIDTH);

    logic [LFSR_MAX_W-1:0] s;

    always_comb begin
        s       = LFSR_MAX_W'(state);
        fb_bits = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            s = lfsr_step(s, TAP_MASK);
            fb_bits[int'(BITS_PER_CYCLE) - 1 - i] = s[0];
        end
        next_state = s[STATE_WIDTH-1:0];
    end

endmodule

// File: rtl/prng_word_gen.sv
// LFSR word generator: assembles OUT_WIDTH-bit words from an unrolled LFSR and offers
// them on a valid/ready interface, with runtime seeding and odd/top-bit forcing.
//
// state | meaning
// IDLE  | waiting for gen_en, LFSR frozen
// FILL  | LFSR advancing, one chunk of BITS_PER_CYCLE bits per clock into the buffer
// HOLD  | completed word presented on out_word until out_ready
module prng_word_gen
    import prng_pkg::*;
#(
    parameter int unsigned            STATE_WIDTH    = 64,
    parameter int unsigned            OUT_WIDTH      = 512,
    parameter int unsigned            BITS_PER_CYCLE = 8,
    parameter logic [STATE_WIDTH-1:0] DEFAULT_SEED   = STATE_WIDTH'(64'hA5A5_5A5A_0F0F_F0F0)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gen_en,
    input  logic                   seed_load,
    input  logic [STATE_WIDTH-1:0] seed_in,
    input  logic                   odd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_word,
    output logic                   busy
);

    localparam int unsigned      NCHUNK     = OUT_WIDTH / BITS_PER_CYCLE;
    localparam int unsigned      CNT_W      = $clog2(NCHUNK + 1);
    localparam int unsigned      IDX_W      = $clog2(OUT_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    if (!(STATE_WIDTH == 32 || STATE_WIDTH == 64 || STATE_WIDTH == 128)) begin : g_bad_state_width
        $error("prng_word_gen: STATE_WIDTH must be 32, 64 or 128");
    end
    if (BITS_PER_CYCLE == 0 || BITS_PER_CYCLE > STATE_WIDTH) begin : g_bad_bpc
        $error("prng_word_gen: BITS_PER_CYCLE must be 1..STATE_WIDTH");
    end
    if (OUT_WIDTH < BITS_PER_CYCLE || (OUT_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_out_width
        $error("prng_word_gen: OUT_WIDTH must be a nonzero multiple of BITS_PER_CYCLE");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("prng_word_gen: DEFAULT_SEED must be nonzero");
    end

    prng_state_e               state_q, state_d;
    logic [STATE_WIDTH-1:0]    lfsr_q, lfsr_d, lfsr_next;
    logic [OUT_WIDTH-1:0]      buf_q, buf_d;
    logic [OUT_WIDTH-1:0]      word_q, word_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BITS_PER_CYCLE-1:0] fb_bits;
    logic [IDX_W-1:0]          chunk_lsb;

    lfsr_unroll #(
        .STATE_WIDTH    (STATE_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_lfsr_unroll (
        .state      (lfsr_q),
        .next_state (lfsr_next),
        .fb_bits    (fb_bits)
    );

    // Chunks are placed from the top down by counter index, which yields the same word as a
    // left-shifting buffer once all NCHUNK chunks are in.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        chunk_lsb = IDX_W'(OUT_WIDTH - BITS_PER_CYCLE - (32'(cnt_q) * BITS_PER_CYCLE));

        unique case (state_q)
            IDLE: begin
                if (gen_en) state_d = FILL;
            end
            FILL: begin
                lfsr_d = lfsr_next;
                buf_d[chunk_lsb +: BITS_PER_CYCLE] = fb_bits;
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d   = '0;
                    word_d  = buf_d;
                    state_d = HOLD;
                    if (odd_mode) begin
                        word_d[0]           = 1'b1;
                        word_d[OUT_WIDTH-1] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) state_d = gen_en ? FILL : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A seed load wins over everything else; a coincident HOLD handshake has still happened.
        if (seed_load) begin
            lfsr_d  = (seed_in == '0) ? DEFAULT_SEED : seed_in;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= DEFAULT_SEED;
            buf_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            buf_q   <= buf_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == FILL);
    assign out_word  = word_q;

endmodule

// File: tb/tb_prng_word_gen.sv
// Directed bench for prng_word_gen: three instances (32/32/1, 64/512/8, 64/512/1)
// checked against an independent bit-serial LFSR model.
module tb_prng_word_gen;

    localparam logic [63:0] SEED_DEF = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [31:0] SEED_A   = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst;

    logic        gen_en_a, seed_load_a, odd_a, ready_a, valid_a, busy_a;
    logic [31:0] seed_in_a, word_a;

    logic         gen_en_b, seed_load_b, odd_b, ready_b, out_valid_b, busy_b;
    logic [63:0]  seed_in_b;
    logic [511:0] out_word_b;

    logic         gen_en_c, seed_load_c, odd_c, ready_c, valid_c, busy_c;
    logic [63:0]  seed_in_c;
    logic [511:0] word_c;

    int n_chk = 0;
    int n_err = 0;
    int acc_b = 0;

    logic [63:0]  m_st;
    logic [31:0]  m32;
    logic [511:0] w, e0, e1, exp0;
    logic [511:0] wb [2];
    logic [511:0] wc [2];
    int           cb [2];
    int           cc [2];
    int           cyc, a0, nb, nc;
    logic         stable;

    prng_word_gen #(
        .STATE_WIDTH(32), .OUT_WIDTH(32), .BITS_PER_CYCLE(1), .DEFAULT_SEED(SEED_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .gen_en(gen_en_a), .seed_load(seed_load_a), .seed_in(seed_in_a),
        .odd_mode(odd_a), .out_valid(valid_a), .out_ready(ready_a), .out_word(word_a), .busy(busy_a)
    );

    prng_word_gen #(
        .STATE_WIDTH(64), .OUT_WIDTH(512), .BITS_PER_CYCLE(8), .DEFAULT_SEED(SEED_DEF)
    ) u_dut_b (
        .clk(clk), .rst(rst), .gen_en(gen_en_b), .seed_load(seed_load_b), .seed_in(seed_in_b),
        .odd_mode(odd_b), .out_valid(out_valid_b), .out_ready(ready_b), .out_word(out_word_b),
        .busy(busy_b)
    );

    prng_word_gen #(
        .STATE_WIDTH(64), .OUT_WIDTH(512), .BITS_PER_CYCLE(1), .DEFAULT_SEED(SEED_DEF)
    ) u_dut_c (
        .clk(clk), .rst(rst), .gen_en(gen_en_c), .seed_load(seed_load_c), .seed_in(seed_in_c),
        .odd_mode(odd_c), .out_valid(valid_c), .out_ready(ready_c), .out_word(word_c), .busy(busy_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid_b && ready_b) acc_b <= acc_b + 1;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_step32(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[29] ^ s[25] ^ s[24]};
    endfunction

    function automatic logic [63:0] m_step64(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    task automatic m_word(input logic odd, output logic [511:0] wo);
        wo = '0;
        for (int i = 0; i < 512; i++) begin
            m_st = m_step64(m_st);
            wo   = {wo[510:0], m_st[0]};
        end
        if (odd) begin
            wo[0]   = 1'b1;
            wo[511] = 1'b1;
        end
    endtask

    task automatic seed_b(input logic [63:0] v);
        seed_in_b   = v;
        seed_load_b = 1'b1;
        tick();
        seed_load_b = 1'b0;
    endtask

    task automatic get_word_b(output logic [511:0] wo, output int c);
        gen_en_b = 1'b1;
        tick();
        gen_en_b = 1'b0;
        c = 1;
        while (!out_valid_b && c < 600) begin
            tick();
            c++;
        end
        wo = out_word_b;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        gen_en_a = 1'b0; seed_load_a = 1'b0; seed_in_a = '0; odd_a = 1'b0; ready_a = 1'b1;
        gen_en_b = 1'b0; seed_load_b = 1'b0; seed_in_b = '0; odd_b = 1'b0; ready_b = 1'b1;
        gen_en_c = 1'b0; seed_load_c = 1'b0; seed_in_c = '0; odd_c = 1'b0; ready_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("rst_valid_b", 512'(out_valid_b), 512'(0));
        check("rst_busy_b",  512'(busy_b),      512'(0));
        check("rst_word_b",  out_word_b,        512'(0));
        check("rst_a",       512'({valid_a, busy_a, word_a}), 512'(0));
        check("rst_c",       512'({valid_c, busy_c}),         512'(0));
        rst = 1'b0;

        // 32-bit instance, one step per clock: word equals the 32-step state.
        gen_en_a = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!valid_a && cyc < 100);
        m32 = SEED_A;
        for (int i = 0; i < 32; i++) m32 = m_step32(m32);
        check("t1_latency", 512'(cyc),    512'(33));
        check("t1_word",    512'(word_a), 512'(m32));
        gen_en_a = 1'b0;
        tick();
        check("t1_valid_drop", 512'(valid_a), 512'(0));

        // BPC=8 vs BPC=1 free-running from the default seed.
        nb = 0;
        nc = 0;
        gen_en_b = 1'b1;
        gen_en_c = 1'b1;
        for (int c = 1; c <= 1030; c++) begin
            tick();
            if (out_valid_b) begin
                if (nb < 2) begin wb[nb] = out_word_b; cb[nb] = c; end
                nb++;
            end
            if (valid_c) begin
                if (nc < 2) begin wc[nc] = word_c; cc[nc] = c; end
                nc++;
            end
        end
        gen_en_b = 1'b0;
        gen_en_c = 1'b0;
        m_st = SEED_DEF;
        m_word(1'b0, exp0);
        m_word(1'b0, e1);
        check("t2_b_first",  512'(cb[0]),         512'(65));
        check("t2_b_period", 512'(cb[1] - cb[0]), 512'(65));
        check("t2_b_count",  512'(nb),            512'(15));
        check("t2_c_first",  512'(cc[0]),         512'(513));
        check("t2_c_period", 512'(cc[1] - cc[0]), 512'(513));
        check("t2_b_vs_c_0", wb[0], wc[0]);
        check("t2_b_vs_c_1", wb[1], wc[1]);
        check("t2_word0",    wb[0], exp0);
        check("t2_word1",    wb[1], e1);

        // Zero seed falls back to the default seed; seed 1 follows the model.
        seed_b(64'h0);
        get_word_b(w, cyc);
        check("t3_zero_seed", w, exp0);
        check("t3_latency",   512'(cyc), 512'(65));
        seed_b(64'h1);
        get_word_b(w, cyc);
        m_st = 64'h1;
        m_word(1'b0, e0);
        check("t3_seed_one", w, e0);

        // Backpressure in HOLD.
        seed_b(64'hDEAD_BEEF_0123_4567);
        m_st = 64'hDEAD_BEEF_0123_4567;
        m_word(1'b0, e0);
        m_word(1'b0, e1);
        ready_b  = 1'b0;
        gen_en_b = 1'b1;
        tick();
        gen_en_b = 1'b0;
        cyc = 1;
        while (!out_valid_b && cyc < 600) begin tick(); cyc++; end
        w = out_word_b;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!out_valid_b || out_word_b !== w) stable = 1'b0;
        end
        check("t4_hold_stable", 512'(stable), 512'(1));
        check("t4_word0",       w,            e0);
        a0       = acc_b;
        ready_b  = 1'b1;
        gen_en_b = 1'b1;
        tick();
        gen_en_b = 1'b0;
        check("t4_valid_drop", 512'(out_valid_b), 512'(0));
        check("t4_one_xfer",   512'(acc_b - a0),  512'(1));
        cyc = 1;
        while (!out_valid_b && cyc < 600) begin tick(); cyc++; end
        check("t4_next_latency", 512'(cyc), 512'(65));
        check("t4_word1",        out_word_b, e1);
        tick();

        // Odd mode forces bit 0 and bit 511.
        odd_b = 1'b1;
        seed_b(64'h0123_4567_89AB_CDEF);
        m_st = 64'h0123_4567_89AB_CDEF;
        for (int k = 0; k < 2; k++) begin
            get_word_b(w, cyc);
            m_word(1'b1, e0);
            check("t5_odd_word", w, e0);
            check("t5_odd_bits", 512'({w[511], w[0]}), 512'(2'b11));
        end
        odd_b = 1'b0;

        // Seed load at chunk 30 discards the partial word.
        seed_b(64'h0F1E_2D3C_4B5A_6978);
        gen_en_b = 1'b1;
        tick();
        gen_en_b = 1'b0;
        check("t6_busy_fill", 512'(busy_b), 512'(1));
        repeat (30) tick();
        seed_b(64'h5555_0000_AAAA_FFFF);
        check("t6_abort_state", 512'({out_valid_b, busy_b}), 512'(0));
        a0 = acc_b;
        get_word_b(w, cyc);
        m_st = 64'h5555_0000_AAAA_FFFF;
        m_word(1'b0, e0);
        check("t6_abort_word", w,                 e0);
        check("t6_abort_xfer", 512'(acc_b - a0),  512'(1));

        // Seed load coincident with a HOLD handshake.
        seed_b(64'h8000_0000_0000_0001);
        ready_b  = 1'b0;
        gen_en_b = 1'b1;
        tick();
        gen_en_b = 1'b0;
        cyc = 1;
        while (!out_valid_b && cyc < 600) begin tick(); cyc++; end
        m_st = 64'h8000_0000_0000_0001;
        m_word(1'b0, e0);
        check("t6_hs_word", out_word_b, e0);
        a0      = acc_b;
        ready_b = 1'b1;
        seed_b(64'h3C3C_C3C3_1234_8765);
        check("t6_hs_count", 512'(acc_b - a0), 512'(1));
        check("t6_hs_state", 512'({out_valid_b, busy_b}), 512'(0));
        get_word_b(w, cyc);
        m_st = 64'h3C3C_C3C3_1234_8765;
        m_word(1'b0, e0);
        check("t6_hs_next",  w,                e0);
        check("t6_hs_total", 512'(acc_b - a0), 512'(2));

        // Asynchronous reset mid-FILL.
        gen_en_b = 1'b1;
        tick();
        gen_en_b = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("t7_async_rst", 512'({out_valid_b, busy_b}), 512'(0));
        check("t7_rst_word",  out_word_b,                  512'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        get_word_b(w, cyc);
        check("t7_post_rst_word", w, exp0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
